// File: rtl/sync_fifo_flags_pkg.sv
// Shared constants and width helpers for the single-clock flagged FIFO.
package sync_fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;

    function automatic int depth_of(input int asize);
        return 1 << asize;
    endfunction

    // Level and thresholds need one extra bit to represent a completely full FIFO.
    function automatic int lvl_w(input int asize);
        return asize + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Handshake, data, threshold and status bundle for sync_fifo_flags.
interface sync_fifo_flags_if #(
    parameter int DSIZE = sync_fifo_pkg::DSIZE_DEF,
    parameter int ASIZE = sync_fifo_pkg::ASIZE_DEF
);
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             rinc;
    logic [ASIZE:0]   af_thresh;
    logic [ASIZE:0]   ae_thresh;
    logic             err_clr;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             almost_full;
    logic             almost_empty;
    logic [ASIZE:0]   level;
    logic             overflow;
    logic             underflow;

    modport master (
        output wdata, winc, rinc, af_thresh, ae_thresh, err_clr,
        input  rdata, wfull, rempty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  wdata, winc, rinc, af_thresh, ae_thresh, err_clr,
        output rdata, wfull, rempty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags_mem.sv
// DSIZE x DEPTH register array: synchronous write port, unregistered read port, no reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);
    localparam int DEPTH = depth_of(ASIZE);

    logic [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact level, programmable almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through read data; default is registered rdata.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    sync_fifo_flags_if.slave    bus
);
    localparam int LW    = lvl_w(ASIZE);
    localparam int DEPTH = depth_of(ASIZE);

    logic [LW-1:0]    wptr, rptr, level_q;
    logic             overflow_q, underflow_q;
    logic             wfull, rempty, wr_ok, rd_ok;
    logic [DSIZE-1:0] rd_word;

    // Flags come only from the registered level, so a same-cycle read never frees space for a write.
    assign wfull  = (level_q == LW'(DEPTH));
    assign rempty = (level_q == '0);
    assign wr_ok  = bus.winc & ~wfull;
    assign rd_ok  = bus.rinc & ~rempty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + LW'(1);
            if (rd_ok) rptr <= rptr + LW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // A new error in the clearing cycle wins over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (bus.winc & wfull)  | (overflow_q  & ~bus.err_clr);
            underflow_q <= (bus.rinc & rempty) | (underflow_q & ~bus.err_clr);
        end
    end

    sync_fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (bus.wdata),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (rd_word)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.rdata = rd_word;
`else
    logic [DSIZE-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata_q <= '0;
        else if (rd_ok) rdata_q <= rd_word;
    end

    assign bus.rdata = rdata_q;
`endif

    assign bus.wfull        = wfull;
    assign bus.rempty       = rempty;
    assign bus.level        = level_q;
    assign bus.almost_full  = (level_q >= bus.af_thresh);
    assign bus.almost_empty = (level_q <= bus.ae_thresh);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised successor to the dual-clock FIFO, for buffering between blocks that share one clock.
- No pointer synchronisers; occupancy is exact every cycle.
- Adds a level count, run-time programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags with clear.
- Storage is a 2**ASIZE-entry register array.

Parameters:
- DSIZE, 8, data width in bits.
- ASIZE, 4, address width; DEPTH = 2**ASIZE entries.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wdata  in  DSIZE  write data.
- winc  in  1  write request.
- rinc  in  1  read request.
- af_thresh  in  ASIZE+1  almost-full threshold (level units).
- ae_thresh  in  ASIZE+1  almost-empty threshold (level units).
- err_clr  in  1  clears sticky error flags.
- rdata  out  DSIZE  read data.
- wfull  out  1  FIFO full.
- rempty  out  1  FIFO empty.
- almost_full  out  1  level >= af_thresh.
- almost_empty  out  1  level <= ae_thresh.
- level  out  ASIZE+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - Pointers, level and rdata = 0.
  - rempty = 1, wfull = 0, overflow = 0, underflow = 0.
  - almost_empty = 1 (level 0 <= any ae_thresh).
  - almost_full = (af_thresh == 0).
  - Memory array is not reset.
- Pointers: wptr and rptr are ASIZE+1-bit binary with wrap bit; addresses are the low ASIZE bits. Wrap from DEPTH-1 to 0 is natural modulo.
- Level register:
  - Updates +1 on write only, -1 on read only, unchanged on both or neither.
  - Always equals wptr - rptr (modulo 2**(ASIZE+1)).
- Accepted operations:
  - wr_ok = winc & !wfull; rd_ok = rinc & !rempty.
  - Both are evaluated on pre-edge flags, so a simultaneous read does not free space for a same-cycle write when full.
- Flags:
  - wfull = (level == DEPTH); rempty = (level == 0).
  - almost_full and almost_empty are compared against the live threshold inputs every cycle.
  - All flags are combinational from registered level only; no input-to-output combinational path except thresholds to almost_* flags.
- Read timing (standard mode):
  - rdata is registered and loads mem[raddr] on the rd_ok edge, so data is visible the cycle after rinc.
  - rdata holds its value when there is no rd_ok.
- Write timing: mem[waddr] <= wdata on wr_ok. Level and flags reflect the write the cycle after.
- Simultaneous winc & rinc:
  - Mid-range: both accepted, level unchanged.
  - Full: read accepted, write dropped, overflow set.
  - Empty: write accepted, read dropped, underflow set.
- Errors:
  - overflow sets on winc & wfull; underflow sets on rinc & rempty.
  - Both are sticky until err_clr.
  - If err_clr and a new error occur in the same cycle, set wins.
- Reset mid-operation: all state returns to reset values immediately, and FIFO contents are discarded.
- Thresholds > DEPTH: almost_full is never asserted; almost_empty is always asserted. This is legal, not an error.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - rdata = mem[raddr] combinationally; the head word is valid whenever rempty = 0.
  - rinc pops the word currently shown.
  - After a write into an empty FIFO, rempty deasserts and rdata shows that word the next cycle.
- Undefined: registered standard mode, as above.
- Flags, level and error behaviour are identical in both modes.

Decomposition:
- Package sync_fifo_pkg holds:
  - Default DSIZE/ASIZE constants.
  - The DEPTH = 2**ASIZE derivation.
  - The level/threshold width function (ASIZE+1).
- One sub-module: sync_fifo_mem, a DSIZE x DEPTH array with a write port and an unregistered read port.
- sync_fifo_flags itself holds the pointers, level, flags, error logic and the mode-dependent rdata register.

Test Plan (DSIZE=8, ASIZE=4, DEPTH=16):
- Reset, then write 0x11..0x20 (16 words) -> level counts 1..16; wfull=1 after the 16th write; then read 16 -> data 0x11..0x20 in order, rempty=1, no error flags.
- With af_thresh=12, ae_thresh=3, fill from 0 -> almost_empty drops when level goes 3->4; almost_full rises when level reaches 12; both revert on drain.
- At level 16, assert winc & rinc with wdata=0xAA -> read returns the head word, level=15, overflow=1, 0xAA never read out. Pulse err_clr -> overflow=0.
- At level 0, assert winc & rinc with wdata=0x55 -> level=1, underflow=1, next read returns 0x55.
- Drive 40 random write/read streams -> pointers wrap at least twice; scoreboard data matches in order; level always equals the model count.
- With SYNC_FIFO_FWFT_EN defined, write 0x3C into empty -> next cycle rempty=0 and rdata=0x3C without rinc; rinc pops it and rempty=1.
- Mid-stream rst_n low at level 7 -> level=0 and rempty=1 asynchronously; subsequent traffic is correct.
